// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pipe
// Description : Decode-to-execute ALU control unit. Decodes the RV32I ALU
//               operation and, optionally, RV32M mul/div. The decoded control
//               is registered into the EX stage with valid/stall/flush
//               handling. Multi-cycle M-ext ops are sequenced by a latency
//               counter, and decode is held off until the op completes.
// Ports       : clk, rst_n              clock, synchronous active-low reset
//               in_valid / in_ready     decode-stage handshake
//               op_b5, funct3,          instruction fields from the decoder
//               funct7_b5, funct7_b0,
//               alu_op
//               ex_stall, flush         EX-stage freeze / squash
//               out_valid, alu_ctrl,    registered EX-stage control
//               md_sel, md_op, illegal
//               md_start, md_abort      single-cycle mul/div launch / kill
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe #(
    parameter int CTRL_W  = 4,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_b5,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    input  logic              funct7_b0,
    input  logic [1:0]        alu_op,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              md_sel,
    output logic [2:0]        md_op,
    output logic              md_start,
    output logic              md_abort,
    output logic              illegal
);

    localparam int c_MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // ALU encodings, zero-extended to CTRL_W
    localparam logic [CTRL_W-1:0] c_ALU_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] c_ALU_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] c_ALU_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] c_ALU_XOR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] c_ALU_SLL  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] c_ALU_SRL  = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] c_ALU_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] c_ALU_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] c_ALU_SRA  = CTRL_W'(4'b1101);
    localparam logic [CTRL_W-1:0] c_ALU_SLTU = CTRL_W'(4'b1111);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out_valid;
    logic [CTRL_W-1:0]  r_alu_ctrl;
    logic               r_md_sel;
    logic [2:0]         r_md_op;
    logic               r_md_start;
    logic               r_md_abort;
    logic               r_illegal;

    logic [CTRL_W-1:0]  w_ctrl;
    logic               w_illegal;
    logic               w_is_m;
    logic               w_accept;
    logic [c_CNT_W-1:0] w_lat_m1;

    // ------------------------------------------------------------------
    // Combinational decode. Illegal and M-ext encodings default to ADD so
    // the ALU never sees an undefined control word.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl    = c_ALU_ADD;
        w_illegal = 1'b0;
        w_is_m    = 1'b0;
        case (alu_op)
            2'b00: w_ctrl = c_ALU_ADD;
            2'b01: w_ctrl = c_ALU_SUB;
            2'b10: begin
                if (op_b5 && funct7_b0) begin
                    if (EN_M != 0) begin
                        w_is_m = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000: w_ctrl = (op_b5 && funct7_b5) ? c_ALU_SUB : c_ALU_ADD;
                        3'b001: w_ctrl = c_ALU_SLL;
                        3'b010: w_ctrl = c_ALU_SLT;
                        3'b011: w_ctrl = c_ALU_SLTU;
                        3'b100: w_ctrl = c_ALU_XOR;
                        // funct7_b5 alone selects SRA: it applies to srai too
                        3'b101: w_ctrl = funct7_b5 ? c_ALU_SRA : c_ALU_SRL;
                        3'b110: w_ctrl = c_ALU_OR;
                        default: w_ctrl = c_ALU_AND;
                    endcase
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign in_ready = (r_state == c_ST_IDLE) && !ex_stall;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_lat_m1 = funct3[2] ? c_DIV_CNT : c_MUL_CNT;

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
            r_md_sel    <= 1'b0;
            r_md_op     <= 3'b000;
            r_md_start  <= 1'b0;
            r_md_abort  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            // Flush wins over stall. The launch cycle is already BUSY, so
            // checking the state covers both a running and a just-started op.
            r_out_valid <= 1'b0;
            r_md_start  <= 1'b0;
            r_md_abort  <= (r_state == c_ST_BUSY);
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
        end else if (!ex_stall) begin
            r_md_start <= 1'b0;
            r_md_abort <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_m) begin
                            r_state     <= c_ST_BUSY;
                            r_cnt       <= w_lat_m1;
                            r_md_start  <= 1'b1;
                            r_md_op     <= funct3;
                            r_md_sel    <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_alu_ctrl  <= c_ALU_ADD;
                            r_illegal   <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_alu_ctrl  <= w_ctrl;
                            r_illegal   <= w_illegal;
                            r_md_sel    <= 1'b0;
                        end
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign md_sel    = r_md_sel;
    assign md_op     = r_md_op;
    assign illegal   = r_illegal;
    // Pulses are masked while frozen; the held register re-emits the pulse
    // in the first unfrozen cycle, when the mul/div datapath can act on it.
    assign md_start  = r_md_start && !ex_stall;
    assign md_abort  = r_md_abort && !ex_stall;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_pipe
// Description : Self-checking bench for alu_ctrl_pipe. A timestamp-based
//               reference model (count of unfrozen clock edges) predicts
//               handshake, result timing and decoded control. Directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_pipe;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SRA = 4'b1101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, op_b5, funct7_b5, funct7_b0, ex_stall, flush;
    logic [2:0] funct3;
    logic [1:0] alu_op;

    logic       in_ready, out_valid, md_sel, md_start, md_abort, illegal;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;

    logic       n_in_ready, n_out_valid, n_md_sel, n_md_start, n_md_abort, n_illegal;
    logic [3:0] n_alu_ctrl;
    logic [2:0] n_md_op;

    alu_ctrl_pipe #(.CTRL_W(4), .EN_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_b5(op_b5), .funct3(funct3), .funct7_b5(funct7_b5), .funct7_b0(funct7_b0),
        .alu_op(alu_op), .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid),
        .alu_ctrl(alu_ctrl), .md_sel(md_sel), .md_op(md_op), .md_start(md_start),
        .md_abort(md_abort), .illegal(illegal)
    );

    // Same stimulus, RV32M disabled
    alu_ctrl_pipe #(.CTRL_W(4), .EN_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .op_b5(op_b5), .funct3(funct3), .funct7_b5(funct7_b5), .funct7_b0(funct7_b0),
        .alu_op(alu_op), .ex_stall(ex_stall), .flush(flush), .out_valid(n_out_valid),
        .alu_ctrl(n_alu_ctrl), .md_sel(n_md_sel), .md_op(n_md_op), .md_start(n_md_start),
        .md_abort(n_md_abort), .illegal(n_illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: everything is keyed on ucnt, the number of clock
    // edges that were not frozen by a stall. Events are scheduled as ucnt
    // values; -1 means "nothing scheduled".
    int         ucnt       = 0;
    bit         m_pending  = 1'b0;
    int         m_due      = -1;
    int         m_start_at = -1;
    logic [2:0] m_op       = 3'b000;
    int         s_at       = -1;
    logic [3:0] s_ctrl     = ADD;
    bit         s_ill      = 1'b0;
    int         abort_at   = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                       input logic ob5, input logic f7b5, input logic f7b0,
                                       input bit en_m, output logic [3:0] ctrl,
                                       output bit ill, output bit is_m);
        logic [3:0] base [8];
        // funct3 -> op: add sll slt sltu xor srl or and
        base = '{4'b0010, 4'b0100, 4'b0111, 4'b1111, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        ctrl = ADD;
        ill  = 1'b0;
        is_m = 1'b0;
        if (aop == 2'b00)      ctrl = ADD;
        else if (aop == 2'b01) ctrl = SUB;
        else if (aop == 2'b11) ill = 1'b1;
        else if (ob5 && f7b0) begin
            if (en_m) is_m = 1'b1;
            else      ill  = 1'b1;
        end else begin
            ctrl = base[f3];
            if (f3 == 3'd0 && ob5 && f7b5) ctrl = SUB;
            if (f3 == 3'd5 && f7b5)        ctrl = SRA;
        end
    endfunction

    // Advance the model across the coming clock edge using current inputs.
    task automatic model_edge();
        bit         busy;
        logic [3:0] ctrl;
        bit         ill, is_m;
        busy = m_pending && (ucnt < m_due);
        if (!rst_n) begin
            ucnt = 0; m_pending = 1'b0; m_due = -1; m_start_at = -1;
            s_at = -1; abort_at = -1;
            return;
        end
        if (flush) begin
            ucnt++;
            m_pending = 1'b0;
            s_at      = -1;
            abort_at  = busy ? ucnt : -1;
            return;
        end
        if (ex_stall) return;
        if (m_pending && ucnt >= m_due) m_pending = 1'b0;
        if (in_valid && !busy) begin
            ref_decode(alu_op, funct3, op_b5, funct7_b5, funct7_b0, 1'b1, ctrl, ill, is_m);
            if (is_m) begin
                m_pending  = 1'b1;
                m_due      = ucnt + (funct3[2] ? DIV_LAT : MUL_LAT);
                m_start_at = ucnt + 1;
                m_op       = funct3;
            end else begin
                s_at   = ucnt + 1;
                s_ctrl = ctrl;
                s_ill  = ill;
            end
        end
        ucnt++;
    endtask

    task automatic check_all();
        bit e_mval, e_sval, e_start;
        e_mval  = m_pending && (ucnt == m_due);
        e_sval  = (s_at == ucnt);
        e_start = m_pending && (ucnt == m_start_at) && !ex_stall;
        chk("in_ready", in_ready, !(m_pending && ucnt < m_due) && !ex_stall);
        chk("out_valid", out_valid, e_mval || e_sval);
        chk("md_start", md_start, e_start);
        chk("md_abort", md_abort, (abort_at == ucnt) && !ex_stall);
        if (e_start) chk("md_op_start", md_op, m_op);
        if (e_mval) begin
            chk("md_sel_m", md_sel, 1'b1);
            chk("md_op_res", md_op, m_op);
            chk("illegal_m", illegal, 1'b0);
        end else if (e_sval) begin
            chk("alu_ctrl", alu_ctrl, s_ctrl);
            chk("illegal", illegal, s_ill);
            chk("md_sel_s", md_sel, 1'b0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #2;
        check_all();
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3,
                          input logic ob5, input logic f7b5, input logic f7b0);
        in_valid = 1'b1; alu_op = aop; funct3 = f3;
        op_b5 = ob5; funct7_b5 = f7b5; funct7_b0 = f7b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_b5 = 1'b0; funct7_b5 = 1'b0; funct7_b0 = 1'b0;
        ex_stall = 1'b0; flush = 1'b0; funct3 = 3'b000; alu_op = 2'b00;
        @(negedge clk);

        // Reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_md_sel", md_sel, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: srai -> SRA
        set_op(2'b10, 3'b101, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_ctrl", alu_ctrl, SRA);

        // 2: addi with funct7_b5 set stays ADD; R-type becomes SUB
        set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t2_addi", alu_ctrl, ADD);
        set_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t2_sub", alu_ctrl, SUB);
        in_valid = 1'b0;
        tick();

        // 3: MUL, result four cycles after accept
        set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3_start", md_start, 1'b1);
        chk("t3_rdy1", in_ready, 1'b0);
        tick(); chk("t3_rdy2", in_ready, 1'b0);
        tick(); chk("t3_rdy3", in_ready, 1'b0);
        tick();
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_md_sel", md_sel, 1'b1);
        chk("t3_md_op", md_op, 3'b000);
        tick();

        // 4: DIV flushed at cycle 10
        set_op(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_abort", md_abort, 1'b1);
        chk("t4_ready", in_ready, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("t4_no_valid", out_valid, 1'b0);
        end

        // 5: DIV with three stalled cycles mid-BUSY -> result at cycle 35
        set_op(2'b10, 3'b110, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_valid", out_valid, 1'b0);
            chk("t5_stall_op", md_op, 3'b110);
        end
        ex_stall = 1'b0;
        repeat (21) tick();
        chk("t5_cyc34", out_valid, 1'b0);
        tick();
        chk("t5_cyc35", out_valid, 1'b1);
        chk("t5_md_op", md_op, 3'b110);
        // Held output survives a stall
        ex_stall = 1'b1;
        tick();
        chk("t5_hold", out_valid, 1'b1);
        ex_stall = 1'b0;
        tick();

        // 6: reserved alu_op, and M encoding on the EN_M=0 instance
        set_op(2'b11, 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_valid", out_valid, 1'b1);
        chk("t6_illegal", illegal, 1'b1);
        chk("t6_ctrl", alu_ctrl, ADD);
        set_op(2'b10, 3'b001, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6n_valid", n_out_valid, 1'b1);
        chk("t6n_illegal", n_illegal, 1'b1);
        chk("t6n_ctrl", n_alu_ctrl, ADD);
        chk("t6n_md_start", n_md_start, 1'b0);
        repeat (5) tick();

        // Reset in the middle of a DIV gives no abort pulse
        set_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_busy_abort", md_abort, 1'b0);
        chk("rst_busy_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            alu_op    = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom);
            funct3    = 3'($urandom);
            op_b5     = 1'($urandom);
            funct7_b5 = 1'($urandom);
            funct7_b0 = ($urandom_range(0, 3) == 0);
            ex_stall  = ($urandom_range(0, 9) < 2);
            flush     = ($urandom_range(0, 29) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
